// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller.
// A hit returns the addressed word in the same cycle. A miss stalls fetch and
// refills the whole line from main memory, one word per req/ack handshake.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | lookup; hit returns data, miss latches line and starts refill
// REFILL | request words 0..LINE_WORDS-1 of the missed line in order
// DONE   | install tag, set valid unless an invalidate arrived meanwhile
module icache_ctrl #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  input  logic        inv,
  output logic [31:0] inst,
  output logic        icache_stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int LINES      = 1 << INDEX_BITS;
  localparam int LINE_WORDS = 1 << OFFSET_BITS;
  localparam int TAG_LSB    = OFFSET_BITS + 2 + INDEX_BITS;
  localparam int TAG_BITS   = 32 - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  logic [LINES-1:0]        valid;
  logic [TAG_BITS-1:0]     tag_mem  [LINES];
  logic [31:0]             data_mem [LINES*LINE_WORDS];
  logic [TAG_BITS-1:0]     miss_tag;
  logic [INDEX_BITS-1:0]   miss_idx;
  logic [OFFSET_BITS-1:0]  wcnt;
  logic                    inv_pend;

  logic [OFFSET_BITS-1:0]  pc_off;
  logic [INDEX_BITS-1:0]   pc_idx;
  logic [TAG_BITS-1:0]     pc_tag;
  logic                    hit;
  logic                    unused_pc_bits;

  assign pc_off         = pc[OFFSET_BITS+1:2];
  assign pc_idx         = pc[TAG_LSB-1:OFFSET_BITS+2];
  assign pc_tag         = pc[31:TAG_LSB];
  assign unused_pc_bits = ^pc[1:0];

  // An invalidate in IDLE wipes the array at the next edge, so the current
  // lookup is treated as not-ready rather than returning soon-stale data.
  assign hit = (state == IDLE) && !inv && valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);

  // Same-cycle hit path; zero whenever the fetch is stalled.
  always_comb begin
    inst         = '0;
    icache_stall = 1'b1;
    if (hit) begin
      inst         = data_mem[{pc_idx, pc_off}];
      icache_stall = 1'b0;
    end
  end

  // Sequencing FSM with registered memory request/address and valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      wcnt     <= '0;
      inv_pend <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv) begin
            valid <= '0;
          end else if (!hit) begin
            miss_tag <= pc_tag;
            miss_idx <= pc_idx;
            wcnt     <= '0;
            inv_pend <= 1'b0;
            mem_req  <= 1'b1;
            mem_addr <= {pc_tag, pc_idx, {OFFSET_BITS{1'b0}}, 2'b00};
            state    <= REFILL;
          end
        end
        REFILL: begin
          if (inv) inv_pend <= 1'b1;
          if (mem_ack) begin
            wcnt <= wcnt + 1'b1;
            if (&wcnt) begin
              mem_req  <= 1'b0;
              mem_addr <= '0;
              state    <= DONE;
            end else begin
              mem_addr <= {miss_tag, miss_idx, wcnt + 1'b1, 2'b00};
            end
          end
        end
        DONE: begin
          // A pending (or same-cycle) invalidate also drops the line just filled.
          if (inv_pend || inv) valid <= '0;
          else                 valid[miss_idx] <= 1'b1;
          inv_pend <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data storage are plain arrays; only valid[] carries reset.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ack) data_mem[{miss_idx, wcnt}] <= mem_rdata;
    if (state == DONE)              tag_mem[miss_idx] <= miss_tag;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: a memory responder with a programmable ack
// delay logs every refill address; fetches count stall cycles against
// hand-computed miss penalties.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        inv;
  logic [31:0] inst;
  logic        icache_stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;
  int ack_wait = 1;
  int ack_cnt = 0;
  logic [31:0] addr_q[$];

  icache_ctrl #(.INDEX_BITS(6), .OFFSET_BITS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .inv          (inv),
    .inst         (inst),
    .icache_stall (icache_stall),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: ack after ack_wait idle cycles of an outstanding request.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n) begin
        if (ack_cnt >= ack_wait) begin
          mem_ack   = 1'b1;
          mem_rdata = memval(mem_addr);
          addr_q.push_back(mem_addr);
          ack_cnt   = 0;
        end else begin
          mem_ack = 1'b0;
          ack_cnt++;
        end
      end else begin
        mem_ack = 1'b0;
        ack_cnt = 0;
      end
    end
  end

  // Fetch pc=a, optionally switch to a2 / pulse inv at stall cycle n, count stalls.
  task automatic fetch(input string tag, input logic [31:0] a, input logic [31:0] a2,
                       input int sw_at, input int inv_at, input int exp_stall);
    int n;
    int bad;
    n   = 0;
    bad = 0;
    @(negedge clk);
    pc  = a;
    inv = 1'b0;
    #1;
    while (icache_stall && n < 300) begin
      if (inst !== 32'h0) bad++;
      n++;
      @(negedge clk);
      if (n == sw_at) pc = a2;
      inv = (n == inv_at);
      #1;
    end
    inv = 1'b0;
    chk_eq({tag, "_stall_cycles"}, n, exp_stall);
    chk_eq({tag, "_inst"}, inst, memval(a2 & 32'hFFFF_FFFC));
    chk_eq({tag, "_inst_zero_when_stalled"}, bad, 0);
    chk_eq({tag, "_req_idle"}, {31'h0, mem_req}, 32'h0);
  endtask

  task automatic check_line(input string tag, input logic [31:0] base);
    for (int i = 0; i < 4; i++)
      chk_eq({tag, "_addr"}, (addr_q.size() > 0) ? addr_q.pop_front() : 32'hDEAD_DEAD,
             base + 32'(4 * i));
  endtask

  task automatic check_no_more(input string tag);
    chk_eq({tag, "_extra_reqs"}, addr_q.size(), 0);
    addr_q.delete();
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    pc    = '0;
    inv   = 1'b1;
    #1;
    chk_eq("rst_stall", {31'h0, icache_stall}, 32'h1);
    chk_eq("rst_inst", inst, 32'h0);
    chk_eq("rst_req", {31'h0, mem_req}, 32'h0);
    chk_eq("rst_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. cold miss, one wait cycle per word
    ack_wait = 1;
    fetch("cold", 32'h0, 32'h0, -1, -1, 10);
    check_line("cold", 32'h0);
    check_no_more("cold");

    // 2. hit in the filled line
    fetch("hit8", 32'h8, 32'h8, -1, -1, 0);
    check_no_more("hit8");

    // 3. conflict eviction and return
    fetch("conf400", 32'h400, 32'h400, -1, -1, 10);
    check_line("conf400", 32'h400);
    fetch("conf0", 32'h0, 32'h0, -1, -1, 10);
    check_line("conf0", 32'h0);
    check_no_more("conf");

    // 4a. invalidate in IDLE: stalled that cycle, no refill, then a full miss
    @(negedge clk);
    pc  = 32'h8;
    inv = 1'b1;
    #1;
    chk_eq("inv_idle_stall", {31'h0, icache_stall}, 32'h1);
    fetch("inv_idle", 32'h8, 32'h8, -1, -1, 10);
    check_line("inv_idle", 32'h0);
    check_no_more("inv_idle");

    // 4b. invalidate mid-refill: line left invalid, refetched; other lines wiped too
    fetch("inv_mid", 32'h10, 32'h10, -1, 3, 20);
    check_line("inv_mid1", 32'h10);
    check_line("inv_mid2", 32'h10);
    check_no_more("inv_mid");
    fetch("inv_wiped", 32'h0, 32'h0, -1, -1, 10);
    check_line("inv_wiped", 32'h0);
    fetch("inv_refill_kept", 32'h14, 32'h14, -1, -1, 0);
    check_no_more("inv_after");

    // 5. reset during refill after two acks
    @(negedge clk);
    pc = 32'h20;
    k  = 0;
    #1;
    while (addr_q.size() < 2 && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk_eq("rstmid_acks", addr_q.size(), 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_eq("rstmid_req", {31'h0, mem_req}, 32'h0);
    chk_eq("rstmid_addr", mem_addr, 32'h0);
    chk_eq("rstmid_stall", {31'h0, icache_stall}, 32'h1);
    chk_eq("rstmid_inst", inst, 32'h0);
    addr_q.delete();
    repeat (2) @(negedge clk);
    inv   = 1'b1;
    rst_n = 1'b1;
    fetch("rstmid_refetch", 32'h20, 32'h20, -1, -1, 10);
    check_line("rstmid_refetch", 32'h20);
    fetch("rstmid_cleared", 32'h0, 32'h0, -1, -1, 10);
    check_line("rstmid_cleared", 32'h0);
    check_no_more("rstmid");

    // 6. back-to-back acks and pc change during refill
    ack_wait = 0;
    fetch("b2b", 32'h30, 32'h30, -1, -1, 6);
    check_line("b2b", 32'h30);
    fetch("pcchg", 32'h40, 32'h54, 2, -1, 12);
    check_line("pcchg1", 32'h40);
    check_line("pcchg2", 32'h50);
    fetch("pcchg_first_kept", 32'h4C, 32'h4C, -1, -1, 0);
    check_no_more("pcchg");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
